mem_arbiter: RTL

Arbiter and sequencer sharing one unified memory port between the instruction-fetch path and the load/store path of the MIPS core. It sits between the datapath (`pc`, `alu_out`, `dmem_wd`, `rd`) and a single-ported, fixed-latency memory. It serialises accesses, counts memory wait states, and returns read data with a one-cycle acknowledge to the owning requester.

---
 rtl/mem_arbiter.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Arbitrates the instruction-fetch and load/store paths of the MIPS core onto
// one fixed-latency, single-ported memory. Accesses are serialised: IDLE
// grants one requester, ACCESS drives the memory for WAIT_STATES+1 cycles,
// and RESP pulses the owner's acknowledge for one cycle.
//
// Parameters:
//   WAIT_STATES  extra memory cycles per access (0..15)
// Ports:
//   clock, reset                 clock and asynchronous active-high reset
//   if_req/if_addr               fetch request and address
//   if_rdata/if_ack              fetched word and one-cycle completion pulse
//   d_req/d_we/d_addr/d_wdata    load/store request
//   d_rdata/d_ack                load data and one-cycle completion pulse
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata   memory port
//   busy                         high whenever the FSM is not IDLE
//
// Build option:
//   MEM_ARB_RR_EN  defined   -> round-robin arbitration on simultaneous requests
//                  undefined -> fixed data-over-fetch priority
`timescale 1ns/1ps

module mem_arbiter #(
  parameter int WAIT_STATES = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);
  localparam logic       OWN_FETCH = 1'b0;
  localparam logic       OWN_DATA  = 1'b1;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        owner_q;
  logic        if_ack_q;
  logic        d_ack_q;
  logic [31:0] if_rdata_q;
  logic [31:0] d_rdata_q;
  logic        mem_en_q;
  logic        mem_we_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic        busy_q;
  logic        grant_data_d;

`ifdef MEM_ARB_RR_EN
  logic        last_q;   // owner granted most recently

  // Round-robin grant: a tie goes to whoever was not served last.
  always_comb begin
    grant_data_d = OWN_FETCH;
    if (d_req && if_req) begin
      grant_data_d = (last_q == OWN_FETCH) ? OWN_DATA : OWN_FETCH;
    end else if (d_req) begin
      grant_data_d = OWN_DATA;
    end else begin
      grant_data_d = OWN_FETCH;
    end
  end
`else
  // Fixed priority grant: a pending data access always wins.
  always_comb begin
    grant_data_d = OWN_FETCH;
    if (d_req) begin
      grant_data_d = OWN_DATA;
    end else begin
      grant_data_d = OWN_FETCH;
    end
  end
`endif

  // Sequencer FSM with all outputs registered; requester inputs are only
  // looked at in IDLE so an in-flight access cannot be disturbed.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      owner_q     <= OWN_FETCH;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      if_rdata_q  <= 32'h0000_0000;
      d_rdata_q   <= 32'h0000_0000;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0000_0000;
      mem_wdata_q <= 32'h0000_0000;
      busy_q      <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_q      <= OWN_FETCH;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (if_req || d_req) begin
            state_q  <= ST_ACCESS;
            cnt_q    <= WAIT_INIT;
            owner_q  <= grant_data_d;
            mem_en_q <= 1'b1;
            busy_q   <= 1'b1;
`ifdef MEM_ARB_RR_EN
            last_q   <= grant_data_d;
`endif
            if (grant_data_d == OWN_DATA) begin
              mem_addr_q  <= d_addr;
              mem_we_q    <= d_we;
              mem_wdata_q <= d_wdata;
            end else begin
              mem_addr_q  <= if_addr;
              mem_we_q    <= 1'b0;
              mem_wdata_q <= 32'h0000_0000;
            end
          end
        end
        ST_ACCESS: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            // Final access cycle: memory data is valid now.
            state_q  <= ST_RESP;
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
            if (owner_q == OWN_DATA) begin
              d_ack_q <= 1'b1;
              if (!mem_we_q) begin
                d_rdata_q <= mem_rdata;
              end
            end else begin
              if_ack_q   <= 1'b1;
              if_rdata_q <= mem_rdata;
            end
          end
        end
        ST_RESP: begin
          // The owner's req is still high here, so never re-grant directly.
          state_q  <= ST_IDLE;
          if_ack_q <= 1'b0;
          d_ack_q  <= 1'b0;
          busy_q   <= 1'b0;
        end
        default: begin
          state_q  <= ST_IDLE;
          if_ack_q <= 1'b0;
          d_ack_q  <= 1'b0;
          mem_en_q <= 1'b0;
          mem_we_q <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign if_rdata  = if_rdata_q;
  assign if_ack    = if_ack_q;
  assign d_rdata   = d_rdata_q;
  assign d_ack     = d_ack_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;

endmodule
